soc_bus_interconnect: RTL and testbench

Parametrised single-master, NUM_SLAVES-slave memory-mapped interconnect that gives the pipelined core's data port register access to SoC peripherals (CLINT, UART, future devices) through one valid/ready request channel per slave. It decodes the address against per-slave base/mask pairs and forwards one transaction at a time. It returns a single-cycle response pulse with read data or an error flag for unmapped or timed-out accesses. It sits between the core's load/store path and the peripheral `req_*` ports in `rv_soc`.

---
 rtl/soc_bus_interconnect.sv | 194 +++++++++++++++++++
 tb/tb_soc_bus_interconnect.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/soc_bus_interconnect.sv
// soc_bus_interconnect: single-master, NUM_SLAVES-slave valid/ready interconnect.
// Decodes the master address against per-slave base/mask pairs. It forwards one
// transaction at a time and returns a one-cycle response pulse.
// Optional feature: define BUS_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES
// cycles without slave ready. The access then completes with an error response.
module soc_bus_interconnect #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*XLEN-1:0] SLAVE_BASE = {NUM_SLAVES{32'h0000_0000}},
  parameter logic [NUM_SLAVES*XLEN-1:0] SLAVE_MASK = {NUM_SLAVES{32'hFFFF_0000}},
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         reset_n,
  // master side
  input  logic                         m_req_valid,
  output logic                         m_req_ready,
  input  logic [XLEN-1:0]              m_req_addr,
  input  logic [DATA_W-1:0]            m_req_wdata,
  input  logic                         m_req_we,
  input  logic [2:0]                   m_req_size,
  output logic                         m_resp_valid,
  output logic [DATA_W-1:0]            m_resp_rdata,
  output logic                         m_resp_err,
  // slave side
  output logic [NUM_SLAVES-1:0]        s_req_valid,
  output logic [XLEN-1:0]              s_req_addr,
  output logic [DATA_W-1:0]            s_req_wdata,
  output logic                         s_req_we,
  output logic [2:0]                   s_req_size,
  input  logic [NUM_SLAVES-1:0]        s_req_ready,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_req_rdata
);

  localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [2:0]          size_q, size_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                dec_hit;
  logic [SEL_W-1:0]    dec_sel;
  logic [XLEN-1:0]     sel_mask;
  logic [DATA_W-1:0]   sel_rdata;
  logic                sel_ready;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  // Address decode of the incoming request; descending scan lets the lowest hit index win.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_req_addr & SLAVE_MASK[i*XLEN +: XLEN]) == SLAVE_BASE[i*XLEN +: XLEN]) begin
        dec_hit = 1'b1;
        dec_sel = SEL_W'(i);
      end
    end
  end

  // Mux the latched selection's mask, read data and ready; other slaves' ready is ignored.
  always_comb begin
    sel_mask  = '0;
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_mask  = SLAVE_MASK[i*XLEN +: XLEN];
        sel_rdata = s_req_rdata[i*DATA_W +: DATA_W];
        sel_ready = s_req_ready[i];
      end
    end
  end

  // FSM next-state and payload/response capture.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (m_req_valid) begin
          addr_d  = m_req_addr;
          wdata_d = m_req_wdata;
          we_d    = m_req_we;
          size_d  = m_req_size;
          if (dec_hit) begin
            sel_d   = dec_sel;
            state_d = ACCESS;
`ifdef BUS_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          rdata_d = we_q ? '0 : sel_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched payload registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // ACCESS wait counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Outputs decoded from state and latched registers only; no path from m_req_* to s_req_*.
  always_comb begin
    m_req_ready  = (state_q == IDLE);
    m_resp_valid = (state_q == RESP);
    m_resp_rdata = (state_q == RESP) ? rdata_q : '0;
    m_resp_err   = (state_q == RESP) ? err_q : 1'b0;
    s_req_valid  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      s_req_valid[i] = (state_q == ACCESS) && (sel_q == SEL_W'(i));
    end
    s_req_addr   = addr_q & ~sel_mask;
    s_req_wdata  = wdata_q;
    s_req_we     = we_q;
    s_req_size   = size_q;
  end

endmodule

// File: tb/tb_soc_bus_interconnect.sv
// Directed testbench for soc_bus_interconnect with three slaves and TIMEOUT_CYCLES=8.
// Timeout scenarios are exercised only when BUS_TIMEOUT_EN is defined.
module tb_soc_bus_interconnect;

  localparam int XLEN = 32;
  localparam int DW   = 64;
  localparam int NS   = 3;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            m_req_valid;
  logic            m_req_ready;
  logic [XLEN-1:0] m_req_addr;
  logic [DW-1:0]   m_req_wdata;
  logic            m_req_we;
  logic [2:0]      m_req_size;
  logic            m_resp_valid;
  logic [DW-1:0]   m_resp_rdata;
  logic            m_resp_err;
  logic [NS-1:0]   s_req_valid;
  logic [XLEN-1:0] s_req_addr;
  logic [DW-1:0]   s_req_wdata;
  logic            s_req_we;
  logic [2:0]      s_req_size;
  logic [NS-1:0]   s_req_ready;
  logic [NS*DW-1:0] s_req_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  soc_bus_interconnect #(
    .XLEN(XLEN), .DATA_W(DW), .NUM_SLAVES(NS),
    .SLAVE_BASE({32'h0200_0000, 32'h1000_0000, 32'h0200_0000}),
    .SLAVE_MASK({32'hFF00_0000, 32'hFFFF_FFF8, 32'hFFFF_0000}),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_wdata(m_req_wdata), .m_req_we(m_req_we), .m_req_size(m_req_size),
    .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata), .m_resp_err(m_resp_err),
    .s_req_valid(s_req_valid), .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata),
    .s_req_we(s_req_we), .s_req_size(s_req_size), .s_req_ready(s_req_ready),
    .s_req_rdata(s_req_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one cycle and settle just after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [63:0] wd, input logic we, input logic [2:0] sz);
    m_req_valid = 1'b1;
    m_req_addr  = a;
    m_req_wdata = wd;
    m_req_we    = we;
    m_req_size  = sz;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    m_req_valid = 1'b0;
    m_req_addr  = '0;
    m_req_wdata = '0;
    m_req_we    = 1'b0;
    m_req_size  = '0;
    s_req_ready = '0;
    s_req_rdata = '0;
    tick();
    tick();
    check_eq("rst_m_req_ready", m_req_ready, 1);
    check_eq("rst_s_req_valid", s_req_valid, 0);
    check_eq("rst_resp_valid", m_resp_valid, 0);
    check_eq("rst_resp_rdata", m_resp_rdata, 0);
    check_eq("rst_resp_err", m_resp_err, 0);
    check_eq("rst_s_req_addr", s_req_addr, 0);
    reset_n = 1'b1;
    tick();

    // 1: read to slave 0 (priority over slave 2), zero-wait
    s_req_rdata[0*DW +: DW] = 64'h1234;
    s_req_rdata[2*DW +: DW] = 64'hBAD2;
    s_req_ready = 3'b101;
    issue(32'h0200_BFF8, 64'h0, 1'b0, 3'd3);
    tick();                      // accept edge
    m_req_valid = 1'b0;
    check_eq("rd_s_valid", s_req_valid, 3'b001);
    check_eq("rd_s_addr", s_req_addr, 32'hBFF8);
    check_eq("rd_s_size", s_req_size, 3'd3);
    check_eq("rd_m_ready_busy", m_req_ready, 0);
    check_eq("rd_no_resp_yet", m_resp_valid, 0);
    tick();
    check_eq("rd_resp_valid", m_resp_valid, 1);
    check_eq("rd_resp_rdata", m_resp_rdata, 64'h1234);
    check_eq("rd_resp_err", m_resp_err, 0);
    check_eq("rd_s_valid_drop", s_req_valid, 0);
    check_eq("rd_m_ready_resp", m_req_ready, 0);
    tick();
    check_eq("rd_resp_pulse", m_resp_valid, 0);
    check_eq("rd_idle_ready", m_req_ready, 1);
    s_req_ready = '0;

    // 2: write to slave 1, three wait cycles
    s_req_rdata[1*DW +: DW] = 64'hDEAD;
    issue(32'h1000_0005, 64'h41, 1'b1, 3'd0);
    tick();
    m_req_valid = 1'b0;
    m_req_wdata = 64'hFFFF;
    for (int k = 1; k <= 4; k++) begin
      check_eq($sformatf("wr_s_valid_%0d", k), s_req_valid, 3'b010);
      check_eq($sformatf("wr_s_addr_%0d", k), s_req_addr, 32'h5);
      check_eq($sformatf("wr_s_wdata_%0d", k), s_req_wdata, 64'h41);
      check_eq($sformatf("wr_s_we_%0d", k), s_req_we, 1);
      check_eq($sformatf("wr_resp_%0d", k), m_resp_valid, 0);
      if (k == 4) s_req_ready = 3'b010;
      tick();
    end
    s_req_ready = '0;
    check_eq("wr_resp_valid", m_resp_valid, 1);
    check_eq("wr_resp_rdata", m_resp_rdata, 0);
    check_eq("wr_resp_err", m_resp_err, 0);
    check_eq("wr_s_valid_drop", s_req_valid, 0);
    tick();
    check_eq("wr_idle", m_req_ready, 1);

    // 3: unmapped read, held valid gives back-to-back error responses
    issue(32'h8000_0000, 64'h0, 1'b0, 3'd2);
    tick();
    check_eq("um_resp_valid", m_resp_valid, 1);
    check_eq("um_resp_err", m_resp_err, 1);
    check_eq("um_resp_rdata", m_resp_rdata, 0);
    check_eq("um_s_valid", s_req_valid, 0);
    check_eq("um_m_ready_resp", m_req_ready, 0);
    tick();
    check_eq("um_idle_gap", m_resp_valid, 0);
    check_eq("um_idle_ready", m_req_ready, 1);
    tick();
    m_req_valid = 1'b0;
    check_eq("um_second_resp", m_resp_valid, 1);
    check_eq("um_second_err", m_resp_err, 1);
    tick();

`ifdef BUS_TIMEOUT_EN
    // 4: timeout, slave never ready
    issue(32'h0200_0010, 64'h0, 1'b0, 3'd2);
    tick();
    m_req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check_eq($sformatf("to_s_valid_%0d", k), s_req_valid, 3'b001);
      tick();
    end
    check_eq("to_resp_valid", m_resp_valid, 1);
    check_eq("to_resp_err", m_resp_err, 1);
    check_eq("to_resp_rdata", m_resp_rdata, 0);
    check_eq("to_s_valid_drop", s_req_valid, 0);
    tick();

    // 5: ready on the final cycle wins
    s_req_rdata[0*DW +: DW] = 64'h55;
    issue(32'h0200_0010, 64'h0, 1'b0, 3'd2);
    tick();
    m_req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check_eq($sformatf("tl_s_valid_%0d", k), s_req_valid, 3'b001);
      if (k == 8) s_req_ready = 3'b001;
      tick();
    end
    s_req_ready = '0;
    check_eq("tl_resp_valid", m_resp_valid, 1);
    check_eq("tl_resp_err", m_resp_err, 0);
    check_eq("tl_resp_rdata", m_resp_rdata, 64'h55);
    tick();
`endif

    // 6: asynchronous reset during ACCESS
    issue(32'h0200_0020, 64'h0, 1'b0, 3'd2);
    tick();
    m_req_valid = 1'b0;
    check_eq("ar_s_valid_before", s_req_valid, 3'b001);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("ar_s_valid_async", s_req_valid, 0);
    check_eq("ar_resp_async", m_resp_valid, 0);
    check_eq("ar_ready_async", m_req_ready, 1);
    s_req_ready = 3'b001;
    tick();
    reset_n = 1'b1;
    s_req_ready = '0;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("ar_no_resp_%0d", k), m_resp_valid, 0);
      tick();
    end
    s_req_rdata[0*DW +: DW] = 64'hCAFE;
    s_req_ready = 3'b001;
    issue(32'h0200_0040, 64'h0, 1'b0, 3'd3);
    tick();
    m_req_valid = 1'b0;
    check_eq("ar_post_s_addr", s_req_addr, 32'h40);
    tick();
    check_eq("ar_post_resp", m_resp_valid, 1);
    check_eq("ar_post_rdata", m_resp_rdata, 64'hCAFE);
    check_eq("ar_post_err", m_resp_err, 0);
    s_req_ready = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
